// File: rtl/uart_rx_core_pkg.sv
`default_nettype none
// ============================================================================
// Module : seg_uart_pkg
// Brief  : Shared UART receive state encoding and protocol byte constants.
// Rev    : 1.0
// ============================================================================
package seg_uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_t;

  localparam logic [7:0] BYTE_GO   = 8'h67;
  localparam logic [7:0] BYTE_STOP = 8'h73;

endpackage
`default_nettype wire

// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_core_if
// Brief  : Serial pin, byte output and status bundle of the UART receiver.
// Rev    : 1.0
// ============================================================================
interface uart_rx_core_if;
  logic       RX;
  logic       clr_rdy;
  logic       rdy;
  logic [7:0] rx_data;
  logic       frm_err;
  logic       ovr_err;

  modport master (output RX, clr_rdy, input rdy, rx_data, frm_err, ovr_err);
  modport slave  (input RX, clr_rdy, output rdy, rx_data, frm_err, ovr_err);
endinterface
`default_nettype wire

// File: rtl/uart_rx_core_sync.sv
`default_nettype none
// ============================================================================
// Module : rx_sync
// Brief  : 2-flop synchroniser (preset high) plus falling-edge detect flop.
// Rev    : 1.0
// ============================================================================
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall
);

  // [0] first sync stage, [1] synchronised level, [2] previous level
  logic [2:0] r_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sh <= 3'b111;
    else        r_sh <= {r_sh[1:0], i_async};
  end

  assign o_sync = r_sh[1];
  assign o_fall = r_sh[2] & ~r_sh[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_core
// Brief  : 8N1 UART receiver with mid-bit sampling, sticky rdy, frame/overrun flags.
// Rev    : 1.0
// ============================================================================
module uart_rx_core
  import seg_uart_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_core_if.slave  bus
);

  localparam int             CW     = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0]  c_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0]  c_FULL = CW'(BAUD_DIV - 1);

  rx_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shreg;
  logic [7:0]    r_data;
  logic          r_rdy, r_frm, r_ovr;
  logic          w_sync, w_fall, w_tick, w_stop_ok, w_stop_bad;

  rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bus.RX),
    .o_sync  (w_sync),
    .o_fall  (w_fall)
  );

  // Counter restarts at 0 on state entry, so START targets half a bit minus one.
  assign w_tick     = (r_state == START) ? (r_baud == c_HALF) : (r_baud == c_FULL);
  assign w_stop_ok  = (r_state == STOP) && w_tick &&  w_sync;
  assign w_stop_bad = (r_state == STOP) && w_tick && !w_sync;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_state_nxt = START;
      START:   if (w_tick) w_state_nxt = w_sync ? IDLE : DATA;
      DATA:    if (w_tick && (r_bit == 3'd7)) w_state_nxt = STOP;
      STOP:    if (w_tick) w_state_nxt = w_sync ? IDLE : WAIT_HI;
      WAIT_HI: if (w_sync) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shreg <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) || (r_state == WAIT_HI) || (w_state_nxt != r_state) || w_tick)
        r_baud <= '0;
      else
        r_baud <= r_baud + 1'b1;
      if (r_state != DATA) r_bit <= 3'd0;
      else if (w_tick)     r_bit <= r_bit + 3'd1;
      if ((r_state == DATA) && w_tick) r_shreg <= {w_sync, r_shreg[7:1]};
    end
  end

  // A completing byte takes priority over a same-cycle acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= 8'h00;
      r_rdy  <= 1'b0;
      r_frm  <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_frm <= w_stop_bad;
      r_ovr <= w_stop_ok && r_rdy && !bus.clr_rdy;
      if (w_stop_ok)        r_data <= r_shreg;
      if (w_stop_ok)        r_rdy  <= 1'b1;
      else if (bus.clr_rdy) r_rdy  <= 1'b0;
    end
  end

  assign bus.rdy     = r_rdy;
  assign bus.rx_data = r_data;
  assign bus.frm_err = r_frm;
  assign bus.ovr_err = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_core
// Brief  : Directed self-checking bench for uart_rx_core at BAUD_DIV=16.
// Rev    : 1.0
// ============================================================================
module tb_uart_rx_core;
  import seg_uart_pkg::*;

  localparam int BD = 16;
  localparam int c_RDY_LAT = 2 + BD/2 + 9*BD + 1;  // frame start -> rdy visible

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   t_start = 0;

  int   rise_cyc = -1, ovr_cyc = -1, frm_cyc = -1;
  int   ovr_cnt = 0, frm_cnt = 0;
  int   ovr_base, frm_base;
  logic rdy_q = 1'b0;

  uart_rx_core_if u_if ();

  uart_rx_core #(.BAUD_DIV(BD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rdy_q <= u_if.rdy;
    if (u_if.rdy && !rdy_q) rise_cyc <= cyc;
    if (u_if.ovr_err) begin ovr_cnt <= ovr_cnt + 1; ovr_cyc <= cyc; end
    if (u_if.frm_err) begin frm_cnt <= frm_cnt + 1; frm_cyc <= cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    t_start  = cyc;
    u_if.RX  = 1'b0;
    repeat (BD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 u_if.RX = b[i];
      repeat (BD) @(posedge clk);
    end
    #1 u_if.RX = stop_bit;
    repeat (BD) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 u_if.clr_rdy = 1'b1;
    @(posedge clk); #1 u_if.clr_rdy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_if.RX      = 1'b1;
    u_if.clr_rdy = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",  u_if.rdy,     0);
    chk("rst_data", u_if.rx_data, 8'h00);
    chk("rst_frm",  u_if.frm_err, 0);
    chk("rst_ovr",  u_if.ovr_err, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // 1: single frame, rdy latency, hold, clear
    send_frame(BYTE_GO, 1'b1);
    chk("t1_lat",  rise_cyc - t_start, c_RDY_LAT);
    chk("t1_data", u_if.rx_data, 8'h67);
    repeat (20) @(posedge clk);
    #1 chk("t1_hold", u_if.rdy, 1);
    u_if.clr_rdy = 1'b1;
    @(posedge clk); #1 u_if.clr_rdy = 1'b0;
    chk("t1_clr", u_if.rdy, 0);

    // 2: back-to-back frames without acknowledge -> overrun
    ovr_base = ovr_cnt;
    send_frame(BYTE_GO, 1'b1);
    send_frame(BYTE_STOP, 1'b1);
    repeat (2) @(posedge clk); #1;
    chk("t2_ovr_cnt", ovr_cnt - ovr_base, 1);
    chk("t2_ovr_lat", ovr_cyc - t_start, c_RDY_LAT);
    chk("t2_data",    u_if.rx_data, 8'h73);
    chk("t2_rdy",     u_if.rdy, 1);
    pulse_clr();

    // 3: short glitch rejected at start check
    ovr_base = ovr_cnt;
    frm_base = frm_cnt;
    @(posedge clk); #1 u_if.RX = 1'b0;
    repeat (4) @(posedge clk); #1 u_if.RX = 1'b1;
    repeat (40) @(posedge clk); #1;
    chk("t3_rdy", u_if.rdy, 0);
    chk("t3_frm", frm_cnt - frm_base, 0);
    chk("t3_ovr", ovr_cnt - ovr_base, 0);

    // 4: framing error with stuck-low line, then recovery
    frm_base = frm_cnt;
    send_frame(8'hA5, 1'b0);
    repeat (40) @(posedge clk); #1 u_if.RX = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("t4_frm_cnt", frm_cnt - frm_base, 1);
    chk("t4_frm_lat", frm_cyc - t_start, c_RDY_LAT);
    chk("t4_data",    u_if.rx_data, 8'h73);
    chk("t4_rdy",     u_if.rdy, 0);
    send_frame(8'h5A, 1'b1);
    chk("t4_next_data", u_if.rx_data, 8'h5A);
    chk("t4_next_rdy",  u_if.rdy, 1);
    pulse_clr();

    // 5: acknowledge coincides with rdy set
    ovr_base = ovr_cnt;
    fork
      send_frame(BYTE_STOP, 1'b1);
      begin
        @(posedge clk); #2;
        while (cyc != t_start + c_RDY_LAT - 1) begin @(posedge clk); #1; end
        u_if.clr_rdy = 1'b1;
        @(posedge clk); #1 u_if.clr_rdy = 1'b0;
      end
    join
    repeat (2) @(posedge clk); #1;
    chk("t5_rdy",  u_if.rdy, 1);
    chk("t5_lat",  rise_cyc - t_start, c_RDY_LAT);
    chk("t5_data", u_if.rx_data, 8'h73);
    chk("t5_ovr",  ovr_cnt - ovr_base, 0);

    // 6: reset during data bit 4, then a clean frame
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clk); #2;
        while (cyc != t_start + 85) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #2;
        chk("t6_rdy",  u_if.rdy, 0);
        chk("t6_data", u_if.rx_data, 8'h00);
        chk("t6_frm",  u_if.frm_err, 0);
        chk("t6_ovr",  u_if.ovr_err, 0);
        repeat (3) @(posedge clk); #1 rst_n = 1'b1;
      end
    join
    repeat (5) @(posedge clk); #1;
    chk("t6_idle_rdy", u_if.rdy, 0);
    send_frame(BYTE_GO, 1'b1);
    chk("t6_post_lat",  rise_cyc - t_start, c_RDY_LAT);
    chk("t6_post_data", u_if.rx_data, 8'h67);
    chk("t6_post_rdy",  u_if.rdy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
